// File: rtl/xtal_qualifier_pkg.sv
// Shared state encoding and parameter-derived widths for the crystal startup qualifier.
package xtal_qualifier_pkg;

  typedef enum logic [2:0] {
    ST_SETTLE  = 3'd0,
    ST_HOLD    = 3'd1,
    ST_RUN     = 3'd2,
    ST_BACKOFF = 3'd3,
    ST_DEAD    = 3'd4
  } state_e;

  // Wide enough to hold the largest terminal count among the three windows.
  function automatic int cnt_width(input int settle, input int hold, input int divide);
    int m;
    m = settle;
    if (hold > m) m = hold;
    if (divide > m) m = divide;
    return $clog2(m + 1);
  endfunction

  function automatic int retry_width(input int max_retry);
    return $clog2(max_retry + 1);
  endfunction

endpackage

// File: rtl/xtal_tick_divider.sv
// Free-running DIVIDE-period tick generator; the tick is registered on the terminal count.
module xtal_tick_divider #(
  parameter int DIVIDE = 8
) (
  input  logic clk,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int DW = (DIVIDE > 1) ? $clog2(DIVIDE) : 1;
  localparam logic [DW-1:0] LAST = DW'(DIVIDE - 1);

  logic [DW-1:0] cnt_q;
  logic          tick_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (clr_i || !en_i) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      tick_q <= (cnt_q == LAST);
      cnt_q  <= (cnt_q == LAST) ? '0 : cnt_q + DW'(1);
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/xtal_clock_qualifier.sv
// Oscillator startup qualifier: settle, hold downstream reset, run with a divided tick,
// and retry with backoff on crystal faults until the retry budget is spent.
module xtal_clock_qualifier
  import xtal_qualifier_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1024,
  parameter int HOLD_CYCLES   = 16,
  parameter int DIVIDE        = 8,
  parameter int MAX_RETRY     = 3
) (
  input  logic                                ClockP,
  input  logic                                Reset,
  input  logic                                XtalFault,
  input  logic                                Restart,
  output logic                                ClockGood,
  output logic                                ResetOut,
  output logic                                DivTick,
  output logic                                Dead,
  output logic [retry_width(MAX_RETRY)-1:0]   RetryCount,
  output logic [2:0]                          State
);

  localparam int CW = cnt_width(SETTLE_CYCLES, HOLD_CYCLES, DIVIDE);
  localparam int RW = retry_width(MAX_RETRY);

  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX   = RW'(MAX_RETRY);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] retry_q, retry_d;
  logic          run_en;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;

    if (Restart) begin
      state_d = ST_SETTLE;
      cnt_d   = '0;
      if (state_q == ST_DEAD) retry_d = '0;
    end else begin
      unique case (state_q)
        ST_SETTLE: begin
          if (XtalFault)                cnt_d = '0;
          else if (cnt_q == SETTLE_LAST) begin
            state_d = ST_HOLD;
            cnt_d   = '0;
          end else                      cnt_d = cnt_q + CW'(1);
        end
        ST_HOLD, ST_RUN: begin
          if (XtalFault) begin
            cnt_d = '0;
            if (retry_q == RETRY_MAX) begin
              state_d = ST_DEAD;
            end else begin
              state_d = ST_BACKOFF;
              retry_d = retry_q + RW'(1);
            end
          end else if (state_q == ST_HOLD) begin
            if (cnt_q == HOLD_LAST) begin
              state_d = ST_RUN;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        // Backoff reuses the hold window length and deliberately ignores faults.
        ST_BACKOFF: begin
          if (cnt_q == HOLD_LAST) begin
            state_d = ST_SETTLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_DEAD: ;
        default: begin
          state_d = ST_SETTLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge ClockP) begin
    if (Reset) begin
      state_q <= ST_SETTLE;
      cnt_q   <= '0;
      retry_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
    end
  end

  // Divider only advances on edges that stay in RUN, so the leaving edge clears the tick.
  assign run_en = (state_q == ST_RUN) && (state_d == ST_RUN);

  xtal_tick_divider #(
    .DIVIDE (DIVIDE)
  ) u_tick_divider (
    .clk    (ClockP),
    .clr_i  (Reset),
    .en_i   (run_en),
    .tick_o (DivTick)
  );

  assign ClockGood  = (state_q == ST_HOLD) || (state_q == ST_RUN);
  assign ResetOut   = (state_q != ST_RUN);
  assign Dead       = (state_q == ST_DEAD);
  assign RetryCount = retry_q;
  assign State      = state_q;

endmodule

// File: tb/tb_xtal_clock_qualifier.sv
// Directed scenarios plus random fault/restart/reset traffic against a behavioural model.
module tb_xtal_clock_qualifier;

  localparam int SETTLE = 8;
  localparam int HOLD   = 4;
  localparam int DIV    = 3;
  localparam int MAXR   = 2;

  logic       ClockP = 1'b0;
  logic       Reset = 1'b1;
  logic       XtalFault = 1'b0;
  logic       Restart = 1'b0;
  logic       ClockGood, ResetOut, DivTick, Dead;
  logic [1:0] RetryCount;
  logic [2:0] State;

  int n_assert = 0;
  int n_fail   = 0;
  int edge_no  = 0;

  // Model: mode per spec encoding, time spent in the current mode, retries, run edges.
  int m_mode = 0, m_time = 0, m_retry = 0, m_run = 0;
  bit m_tick = 0;

  xtal_clock_qualifier #(
    .SETTLE_CYCLES (SETTLE),
    .HOLD_CYCLES   (HOLD),
    .DIVIDE        (DIV),
    .MAX_RETRY     (MAXR)
  ) dut (
    .ClockP     (ClockP),
    .Reset      (Reset),
    .XtalFault  (XtalFault),
    .Restart    (Restart),
    .ClockGood  (ClockGood),
    .ResetOut   (ResetOut),
    .DivTick    (DivTick),
    .Dead       (Dead),
    .RetryCount (RetryCount),
    .State      (State)
  );

  always #5 ClockP = ~ClockP;

  initial begin
    #300000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit f, input bit rs, input bit rst);
    m_tick = 0;
    if (rst) begin
      m_mode = 0; m_time = 0; m_retry = 0;
    end else if (rs) begin
      if (m_mode == 4) m_retry = 0;
      m_mode = 0; m_time = 0;
    end else if (f && (m_mode == 1 || m_mode == 2)) begin
      m_time = 0;
      if (m_retry == MAXR) m_mode = 4;
      else begin m_retry++; m_mode = 3; end
    end else begin
      case (m_mode)
        0: begin
          m_time = f ? 0 : m_time + 1;
          if (m_time == SETTLE) begin m_mode = 1; m_time = 0; end
        end
        1: begin
          m_time++;
          if (m_time == HOLD) begin m_mode = 2; m_time = 0; m_run = 0; end
        end
        2: begin
          m_run++;
          m_tick = (m_run % DIV) == 0;
        end
        3: begin
          m_time++;
          if (m_time == HOLD) begin m_mode = 0; m_time = 0; end
        end
        default: ;
      endcase
    end
  endtask

  task automatic cyc(input bit f, input bit rs, input bit rst);
    @(negedge ClockP);
    XtalFault = f; Restart = rs; Reset = rst;
    @(posedge ClockP);
    #1;
    model_step(f, rs, rst);
    edge_no = rst ? 0 : edge_no + 1;
    check("state",  32'(State),      32'(m_mode));
    check("good",   32'(ClockGood),  32'(m_mode == 1 || m_mode == 2));
    check("rstout", 32'(ResetOut),   32'(m_mode != 2));
    check("tick",   32'(DivTick),    32'(m_tick));
    check("dead",   32'(Dead),       32'(m_mode == 4));
    check("retry",  32'(RetryCount), 32'(m_retry));
  endtask

  task automatic reach_run();
    for (int i = 0; i < 100 && m_mode != 2; i++) cyc(0, 0, 0);
    check("reach_run", 32'(State), 32'd2);
  endtask

  initial begin
    // Reset state
    repeat (3) cyc(0, 0, 1);
    check("rst_good", 32'(ClockGood), 32'd0);
    check("rst_rstout", 32'(ResetOut), 32'd1);

    // Clean start
    for (int e = 1; e <= 21; e++) begin
      cyc(0, 0, 0);
      check("s1_good", 32'(ClockGood), 32'(e >= SETTLE));
      check("s1_rstout", 32'(ResetOut), 32'(e < SETTLE + HOLD));
      check("s1_tick", 32'(DivTick), 32'(e > 12 && (e - 12) % DIV == 0));
    end
    check("s1_retry", 32'(RetryCount), 32'd0);

    // Fault during settle restarts the window without consuming a retry
    cyc(0, 0, 1);
    for (int e = 1; e <= 13; e++) begin
      cyc(e == 5, 0, 0);
      check("s2_good", 32'(ClockGood), 32'(e >= 13));
    end
    check("s2_retry", 32'(RetryCount), 32'd0);

    // Fault in RUN -> backoff -> resettle
    cyc(0, 0, 1);
    for (int e = 1; e <= 26; e++) begin
      cyc(e == 14, 0, 0);
      if (e == 14) begin
        check("s3_state", 32'(State), 32'd3);
        check("s3_good", 32'(ClockGood), 32'd0);
        check("s3_retry", 32'(RetryCount), 32'd1);
        check("s3_tick", 32'(DivTick), 32'd0);
      end
      if (e == 17) check("s3_still_backoff", 32'(State), 32'd3);
      if (e == 18) check("s3_settle", 32'(State), 32'd0);
      if (e >= 18) check("s3_good2", 32'(ClockGood), 32'(e >= 26));
    end

    // Three faults after qualification -> DEAD, sticky until Restart
    cyc(0, 0, 1);
    for (int k = 0; k < 3; k++) begin
      reach_run();
      cyc(1, 0, 0);
    end
    check("s4_state", 32'(State), 32'd4);
    check("s4_dead", 32'(Dead), 32'd1);
    for (int i = 0; i < 6; i++) cyc(i[0], 0, 0);
    check("s4_sticky", 32'(State), 32'd4);
    cyc(0, 1, 0);
    check("s4_restart_state", 32'(State), 32'd0);
    check("s4_restart_dead", 32'(Dead), 32'd0);
    check("s4_restart_retry", 32'(RetryCount), 32'd0);
    for (int e = 1; e <= SETTLE; e++) begin
      cyc(0, 0, 0);
      check("s4_good", 32'(ClockGood), 32'(e == SETTLE));
    end

    // Restart beats a simultaneous fault in RUN
    cyc(0, 0, 1);
    reach_run();
    cyc(1, 0, 0);
    reach_run();
    cyc(1, 1, 0);
    check("s5_state", 32'(State), 32'd0);
    check("s5_retry", 32'(RetryCount), 32'd1);

    // Reset mid-HOLD
    cyc(0, 0, 1);
    repeat (10) cyc(0, 0, 0);
    check("s6_in_hold", 32'(State), 32'd1);
    cyc(0, 0, 1);
    check("s6_good", 32'(ClockGood), 32'd0);
    check("s6_rstout", 32'(ResetOut), 32'd1);
    check("s6_state", 32'(State), 32'd0);

    // Random traffic
    for (int i = 0; i < 1500; i++)
      cyc(($urandom % 100) < 4, ($urandom % 100) < 1, ($urandom % 1000) < 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
